// File: rtl/alarm_match_controller.sv
// Alarm match controller.
// Holds a programmable alarm time and day-of-week mask, detects minute changes on the
// packed current-time word and runs the alarm FSM (disarmed, armed, ringing, snooze).
//
// Ports:
//   Clk       system clock, rising edge
//   Clr_n     synchronous active-low reset
//   CTO       current time {day[2:0], hour[4:0], min_tens[2:0], min_units[3:0]}
//   ATI, DMI  alarm time / day mask to load when LD_AT is high
//   LD_AT     load strobe
//   AL_EN     alarm enable level; low forces the disarmed state
//   SNZ, STOP one-cycle snooze / stop requests
//   ATO, DMO  stored alarm time / day mask
//   Buzz      high only while ringing (registered)
//   Snoozing  high only while snoozing (registered)
//   LD_ERR    sticky flag, last load attempt carried an invalid time
module alarm_match_controller #(
  parameter int unsigned SNOOZE_MIN       = 5,
  parameter int unsigned RING_TIMEOUT_MIN = 10,
  parameter int unsigned MAX_SNOOZE       = 3
) (
  input  logic        Clk,
  input  logic        Clr_n,
  input  logic [14:0] CTO,
  input  logic [11:0] ATI,
  input  logic [6:0]  DMI,
  input  logic        LD_AT,
  input  logic        AL_EN,
  input  logic        SNZ,
  input  logic        STOP,
  output logic [11:0] ATO,
  output logic [6:0]  DMO,
  output logic        Buzz,
  output logic        Snoozing,
  output logic        LD_ERR
);

  localparam logic [4:0] SnzAdd   = 5'(SNOOZE_MIN);
  localparam logic [4:0] RingLast = 5'(RING_TIMEOUT_MIN - 1);
  localparam logic [2:0] MaxSnz   = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {StDisarmed, StArmed, StRinging, StSnooze} state_e;

  state_e      state_q, state_d;
  logic [11:0] ato_q, ato_d;
  logic [6:0]  dmo_q, dmo_d;
  logic        ld_err_q, ld_err_d;
  logic [2:0]  snz_cnt_q, snz_cnt_d;
  logic [4:0]  ring_cnt_q, ring_cnt_d;
  logic [11:0] snz_tgt_q, snz_tgt_d;
  logic [11:0] prev_q;
  logic        prev_valid_q;
  logic        buzz_q, snoozing_q;

  logic        me;
  logic        at_valid;
  logic        day_ok;
  logic [7:0]  dmo_ext;

  // Add the snooze length to an hh:mm word with BCD minutes, wrapping at 24:00.
  function automatic logic [11:0] add_snooze(input logic [11:0] t);
    logic [4:0] u;
    logic [2:0] tens;
    logic [4:0] hr;
    u    = {1'b0, t[3:0]} + SnzAdd;
    tens = t[6:4];
    hr   = t[11:7];
    if (u >= 5'd10) begin
      u = u - 5'd10;
      if (tens == 3'd5) begin
        tens = 3'd0;
        hr   = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
      end else begin
        tens = tens + 3'd1;
      end
    end
    return {hr, tens, u[3:0]};
  endfunction

  assign me       = prev_valid_q && (CTO[11:0] != prev_q);
  assign at_valid = (ATI[3:0] <= 4'd9) && (ATI[6:4] <= 3'd5) && (ATI[11:7] <= 5'd23);
  // Bit 7 is zero so a day value of 7 never matches.
  assign dmo_ext  = {1'b0, dmo_q};
  assign day_ok   = dmo_ext[CTO[14:12]];

  always_comb begin
    state_d    = state_q;
    ato_d      = ato_q;
    dmo_d      = dmo_q;
    ld_err_d   = ld_err_q;
    snz_cnt_d  = snz_cnt_q;
    ring_cnt_d = ring_cnt_q;
    snz_tgt_d  = snz_tgt_q;

    // Register loading happens regardless of AL_EN; only the state is overridden by it.
    if (LD_AT) begin
      if (at_valid) begin
        ato_d     = ATI;
        dmo_d     = DMI;
        ld_err_d  = 1'b0;
        snz_cnt_d = 3'd0;
      end else begin
        ld_err_d  = 1'b1;
      end
    end

    if (!AL_EN) begin
      state_d = StDisarmed;
    end else if (LD_AT) begin
      // A load cycle swallows STOP/SNZ/minute events.
      if (at_valid || state_q == StDisarmed) state_d = StArmed;
    end else begin
      unique case (state_q)
        StDisarmed: state_d = StArmed;
        StArmed: begin
          if (me && CTO[11:0] == ato_q && day_ok) begin
            state_d    = StRinging;
            ring_cnt_d = 5'd0;
            snz_cnt_d  = 3'd0;
          end
        end
        StRinging: begin
          if (STOP) begin
            state_d = StArmed;
          end else if (SNZ && snz_cnt_q < MaxSnz) begin
            state_d   = StSnooze;
            snz_cnt_d = snz_cnt_q + 3'd1;
            snz_tgt_d = add_snooze(CTO[11:0]);
          end else if (me) begin
            if (ring_cnt_q == RingLast) state_d = StArmed;
            else ring_cnt_d = ring_cnt_q + 5'd1;
          end
        end
        StSnooze: begin
          if (STOP) begin
            state_d = StArmed;
          end else if (me && CTO[11:0] == snz_tgt_q) begin
            state_d    = StRinging;
            ring_cnt_d = 5'd0;
          end
        end
        default: state_d = StDisarmed;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      state_q      <= StDisarmed;
      ato_q        <= '0;
      dmo_q        <= '0;
      ld_err_q     <= 1'b0;
      snz_cnt_q    <= '0;
      ring_cnt_q   <= '0;
      snz_tgt_q    <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      buzz_q       <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ato_q        <= ato_d;
      dmo_q        <= dmo_d;
      ld_err_q     <= ld_err_d;
      snz_cnt_q    <= snz_cnt_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_tgt_q    <= snz_tgt_d;
      prev_q       <= CTO[11:0];
      prev_valid_q <= 1'b1;
      buzz_q       <= (state_d == StRinging);
      snoozing_q   <= (state_d == StSnooze);
    end
  end

  assign ATO      = ato_q;
  assign DMO      = dmo_q;
  assign Buzz     = buzz_q;
  assign Snoozing = snoozing_q;
  assign LD_ERR   = ld_err_q;

endmodule
